// File: rtl/v_issue_ctrl.sv
// Vector issue controller: classifies decoded instructions, tracks per-unit busy and
// per-register pending state, and issues start pulses once all hazards are clear.
module v_issue_ctrl #(
  parameter int VREG_NUM    = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic                   is_vconfig,
  input  logic [3:0]             v_alu_op,
  input  logic                   is_mul,
  input  logic [2:0]             v_red_op,
  input  logic [2:0]             v_sldu_op,
  input  logic [3:0]             v_lsu_op,
  input  logic [2:0]             v_op_sel_A,
  input  logic [1:0]             v_op_sel_B,
  input  logic [4:0]             vd,
  input  logic [4:0]             vs1,
  input  logic [4:0]             vs2,
  output logic                   start_alu,
  output logic                   start_mul,
  output logic                   start_red,
  output logic                   start_sldu,
  output logic                   start_lsu,
  output logic [3:0]             issue_op,
  output logic [4:0]             issue_vd,
  input  logic                   done_alu,
  input  logic                   done_mul,
  input  logic                   done_red,
  input  logic                   done_sldu,
  input  logic                   done_lsu,
  output logic                   cfg_we,
  output logic                   idle,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  // Unit bit order: 0=ALU 1=MUL 2=RED 3=SLDU 4=LSU
  typedef enum logic {S_RUN, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [4:0]            busy_q, busy_d, start_q, done_vec;
  logic [VREG_NUM-1:0]   pend_q, pend_d;
  logic [4:0][4:0]       rec_vd_q, rec_vd_d;
  logic [3:0]            issue_op_q, op_sel;
  logic [4:0]            issue_vd_q, unit_sel;
  logic                  cfg_we_q, is_store, is_nop, writes_vd, any_busy;
  logic                  struct_haz, raw_haz, waw_haz, accept;
  logic [STALL_CNT_W-1:0] stall_q;

  always_comb begin
    unit_sel = '0;
    op_sel   = '0;
    is_store = 1'b0;
    if (is_vconfig) begin
      unit_sel = '0;
    end else if (v_lsu_op != 4'd0) begin
      unit_sel[4] = 1'b1;
      op_sel      = v_lsu_op;
      is_store    = (v_lsu_op >= 4'd7) && (v_lsu_op <= 4'd12);
    end else if (v_red_op != 3'd0) begin
      unit_sel[2] = 1'b1;
      op_sel      = {1'b0, v_red_op};
    end else if (v_sldu_op != 3'd0) begin
      unit_sel[3] = 1'b1;
      op_sel      = {1'b0, v_sldu_op};
    end else if (is_mul) begin
      unit_sel[1] = 1'b1;
      op_sel      = 4'd1;
    end else if (v_alu_op != 4'd0) begin
      unit_sel[0] = 1'b1;
      op_sel      = v_alu_op;
    end
  end

  assign is_nop     = !is_vconfig && (unit_sel == 5'd0);
  assign writes_vd  = (unit_sel != 5'd0) && !is_store;
  assign any_busy   = |busy_q;
  // Hazards use registered state only; a same-cycle done never unblocks an issue.
  assign struct_haz = |(unit_sel & busy_q);
  assign raw_haz    = (v_op_sel_A == 3'd1 && pend_q[vs1]) ||
                      (v_op_sel_B == 2'd1 && pend_q[vs2]) ||
                      (is_store && pend_q[vd]);
  assign waw_haz    = writes_vd && pend_q[vd];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (instr_valid && is_vconfig && any_busy) state_d = S_DRAIN;
      S_DRAIN: if (!instr_valid || (is_vconfig && !any_busy)) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    case (state_q)
      S_RUN: begin
        if (is_vconfig)  instr_ready = !any_busy;
        else if (is_nop) instr_ready = 1'b1;
        else             instr_ready = !struct_haz && !raw_haz && !waw_haz;
      end
      S_DRAIN: instr_ready = is_vconfig && !any_busy;
      default: instr_ready = 1'b0;
    endcase
  end

  assign accept   = instr_valid && instr_ready;
  assign done_vec = {done_lsu, done_sldu, done_red, done_mul, done_alu} & busy_q;

  // Completions retire first, then the accepted instruction claims its unit and vd.
  always_comb begin
    busy_d   = busy_q & ~done_vec;
    pend_d   = pend_q;
    rec_vd_d = rec_vd_q;
    for (int u = 0; u < 5; u++)
      if (done_vec[u]) pend_d[rec_vd_q[u]] = 1'b0;
    if (accept) begin
      busy_d = busy_d | unit_sel;
      if (writes_vd) pend_d[vd] = 1'b1;
      for (int u = 0; u < 5; u++)
        if (unit_sel[u]) rec_vd_d[u] = vd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      pend_q     <= '0;
      rec_vd_q   <= '0;
      start_q    <= '0;
      cfg_we_q   <= 1'b0;
      issue_op_q <= '0;
      issue_vd_q <= '0;
      stall_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      rec_vd_q <= rec_vd_d;
      start_q  <= accept ? unit_sel : 5'd0;
      cfg_we_q <= accept && is_vconfig;
      if (accept && unit_sel != 5'd0) begin
        issue_op_q <= op_sel;
        issue_vd_q <= vd;
      end
      if (instr_valid && !instr_ready && stall_q != {STALL_CNT_W{1'b1}})
        stall_q <= stall_q + 1'b1;
    end
  end

  assign {start_lsu, start_sldu, start_red, start_mul, start_alu} = start_q;
  assign issue_op  = issue_op_q;
  assign issue_vd  = issue_vd_q;
  assign cfg_we    = cfg_we_q;
  assign stall_cnt = stall_q;
  assign idle      = !any_busy && (pend_q == '0) && (state_q == S_RUN);
endmodule

// File: tb/tb_v_issue_ctrl.sv
// Directed bench for v_issue_ctrl: one task per scenario, hand-computed expectations.
module tb_v_issue_ctrl;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst, instr_valid, instr_ready, is_vconfig, is_mul;
  logic [3:0] v_alu_op, v_lsu_op, issue_op;
  logic [2:0] v_red_op, v_sldu_op, v_op_sel_A;
  logic [1:0] v_op_sel_B;
  logic [4:0] vd, vs1, vs2, issue_vd;
  logic start_alu, start_mul, start_red, start_sldu, start_lsu;
  logic done_alu, done_mul, done_red, done_sldu, done_lsu;
  logic cfg_we, idle;
  logic [SW-1:0] stall_cnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  v_issue_ctrl #(.VREG_NUM(32), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .is_vconfig(is_vconfig), .v_alu_op(v_alu_op), .is_mul(is_mul), .v_red_op(v_red_op),
    .v_sldu_op(v_sldu_op), .v_lsu_op(v_lsu_op), .v_op_sel_A(v_op_sel_A),
    .v_op_sel_B(v_op_sel_B), .vd(vd), .vs1(vs1), .vs2(vs2),
    .start_alu(start_alu), .start_mul(start_mul), .start_red(start_red),
    .start_sldu(start_sldu), .start_lsu(start_lsu), .issue_op(issue_op), .issue_vd(issue_vd),
    .done_alu(done_alu), .done_mul(done_mul), .done_red(done_red), .done_sldu(done_sldu),
    .done_lsu(done_lsu), .cfg_we(cfg_we), .idle(idle), .stall_cnt(stall_cnt)
  );

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic cfg, input logic [3:0] alu, input logic mul,
                     input logic [2:0] red, input logic [2:0] sldu, input logic [3:0] lsu,
                     input logic [2:0] sa, input logic [1:0] sb,
                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    instr_valid = v; is_vconfig = cfg; v_alu_op = alu; is_mul = mul; v_red_op = red;
    v_sldu_op = sldu; v_lsu_op = lsu; v_op_sel_A = sa; v_op_sel_B = sb;
    vd = d; vs1 = s1; vs2 = s2;
  endtask

  task automatic drv_idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drv_idle();
    {done_alu, done_mul, done_red, done_sldu, done_lsu} = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #4;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %0b want 1", idle); end
    total++; if ({start_alu, start_mul, start_red, start_sldu, start_lsu, cfg_we} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 000000",
                      {start_alu, start_mul, start_red, start_sldu, start_lsu, cfg_we}); end
    total++; if ({issue_op, issue_vd} !== 9'd0) begin
      bad++; $display("FAIL reset_issue: got op=%0d vd=%0d want 0/0", issue_op, issue_vd); end
    total++; if (stall_cnt !== 8'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    drv(1, 0, 4'd3, 0, 0, 0, 0, 3'd1, 2'd1, 5'd8, 5'd9, 5'd10);
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", instr_ready); end
    drv_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drv(1, 0, 4'd3, 0, 0, 0, 0, 0, 0, 5'd1, 0, 0);
    #4;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_alu: got %0b want 1", instr_ready); end
    cyc();
    drv(1, 0, 0, 1, 0, 0, 0, 0, 0, 5'd2, 0, 0);
    #4;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_mul: got %0b want 1", instr_ready); end
    total++; if ({start_alu, start_mul, issue_op, issue_vd} !== {1'b1, 1'b0, 4'd3, 5'd1}) begin
      bad++; $display("FAIL b2b_start_alu: got alu=%0b mul=%0b op=%0d vd=%0d want 1 0 3 1",
                      start_alu, start_mul, issue_op, issue_vd); end
    cyc();
    drv(1, 0, 0, 0, 0, 3'd2, 0, 0, 0, 5'd1, 0, 0);
    #4;
    total++; if ({start_alu, start_mul, issue_op, issue_vd} !== {1'b0, 1'b1, 4'd1, 5'd2}) begin
      bad++; $display("FAIL b2b_start_mul: got alu=%0b mul=%0b op=%0d vd=%0d want 0 1 1 2",
                      start_alu, start_mul, issue_op, issue_vd); end
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL b2b_waw_v1: got %0b want 0", instr_ready); end
    vd = 5'd2; #1;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL b2b_waw_v2: got %0b want 0", instr_ready); end
    vd = 5'd5; #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL b2b_free_v5: got %0b want 1", instr_ready); end
    drv_idle();
    cyc();
    done_alu = 1'b1; done_mul = 1'b1;
    cyc();
    done_alu = 1'b0; done_mul = 1'b0;
    #4;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL b2b_idle_after_done: got %0b want 1", idle); end
  endtask

  task automatic test_priority();
    do_reset();
    drv(1, 0, 4'd5, 1, 3'd1, 0, 4'd2, 0, 0, 5'd9, 0, 0);
    cyc();
    drv(1, 0, 4'd5, 1, 3'd3, 3'd2, 0, 0, 0, 5'd10, 0, 0);
    #4;
    total++; if ({start_lsu, start_red, start_alu, start_mul, issue_op} !== {4'b1000, 4'd2}) begin
      bad++; $display("FAIL prio_lsu: got lsu=%0b red=%0b alu=%0b mul=%0b op=%0d want 1 0 0 0 2",
                      start_lsu, start_red, start_alu, start_mul, issue_op); end
    cyc();
    drv(1, 0, 0, 0, 0, 0, 0, 3'd1, 0, 5'd11, 5'd9, 0);
    #4;
    total++; if ({start_red, start_sldu, start_mul, issue_op, issue_vd} !== {3'b100, 4'd3, 5'd10}) begin
      bad++; $display("FAIL prio_red: got red=%0b sldu=%0b mul=%0b op=%0d vd=%0d want 1 0 0 3 10",
                      start_red, start_sldu, start_mul, issue_op, issue_vd); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL prio_nop_ready: got %0b want 1", instr_ready); end
    drv_idle();
  endtask

  task automatic test_raw();
    do_reset();
    drv(1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 5'd3, 0, 0);
    cyc();
    drv(1, 0, 4'd1, 0, 0, 0, 0, 0, 2'd1, 5'd6, 0, 5'd3);
    #4;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL raw_stall0: got %0b want 0", instr_ready); end
    cyc(); #4;
    total++; if (stall_cnt !== 8'd1) begin bad++; $display("FAIL raw_cnt1: got %0d want 1", stall_cnt); end
    cyc();
    done_alu = 1'b1;
    #4;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL raw_no_bypass: got %0b want 0", instr_ready); end
    total++; if (stall_cnt !== 8'd2) begin bad++; $display("FAIL raw_cnt2: got %0d want 2", stall_cnt); end
    cyc();
    done_alu = 1'b0;
    #4;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL raw_release: got %0b want 1", instr_ready); end
    total++; if (stall_cnt !== 8'd3) begin bad++; $display("FAIL raw_cnt3: got %0d want 3", stall_cnt); end
    cyc();
    drv_idle();
    #4;
    total++; if ({start_alu, issue_op, issue_vd} !== {1'b1, 4'd1, 5'd6}) begin
      bad++; $display("FAIL raw_issue: got start=%0b op=%0d vd=%0d want 1 1 6", start_alu, issue_op, issue_vd); end
    total++; if (stall_cnt !== 8'd3) begin bad++; $display("FAIL raw_cnt_hold: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_struct();
    do_reset();
    drv(1, 0, 0, 0, 0, 0, 4'd1, 0, 0, 5'd4, 0, 0);
    cyc();
    drv(1, 0, 0, 0, 0, 0, 4'd7, 0, 0, 5'd5, 0, 0);
    #4;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL st_busy: got %0b want 0", instr_ready); end
    cyc();
    done_lsu = 1'b1;
    #4;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL st_no_bypass: got %0b want 0", instr_ready); end
    cyc();
    done_lsu = 1'b0;
    #4;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL st_release: got %0b want 1", instr_ready); end
    cyc();
    drv(1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 5'd5, 0, 0);
    #4;
    total++; if ({start_lsu, issue_op, issue_vd} !== {1'b1, 4'd7, 5'd5}) begin
      bad++; $display("FAIL st_issue: got start=%0b op=%0d vd=%0d want 1 7 5", start_lsu, issue_op, issue_vd); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL st_v5_not_pending: got %0b want 1", instr_ready); end
    drv_idle();
    cyc();
    done_lsu = 1'b1;
    cyc();
    done_lsu = 1'b0;
    #4;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL st_idle: got %0b want 1", idle); end
  endtask

  task automatic test_vconfig_drain();
    do_reset();
    drv(1, 0, 4'd4, 0, 0, 0, 0, 0, 0, 5'd1, 0, 0);
    cyc();
    drv(1, 0, 0, 0, 3'd2, 0, 0, 0, 0, 5'd2, 0, 0);
    cyc();
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL cfg_blocked: got %0b want 0", instr_ready); end
    cyc();
    is_vconfig = 1'b0;
    #1;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL cfg_drain_nop: got %0b want 0", instr_ready); end
    is_vconfig = 1'b1;
    done_alu = 1'b1;
    #3;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL cfg_drain_busy: got %0b want 0", instr_ready); end
    cyc();
    done_alu = 1'b0; done_red = 1'b1;
    cyc();
    done_red = 1'b0;
    #4;
    total++; if ({instr_ready, cfg_we} !== 2'b10) begin
      bad++; $display("FAIL cfg_ready: got ready=%0b we=%0b want 1 0", instr_ready, cfg_we); end
    cyc();
    drv_idle();
    #4;
    total++; if ({cfg_we, start_alu, start_red, start_lsu} !== 4'b1000) begin
      bad++; $display("FAIL cfg_we_pulse: got %b want 1000", {cfg_we, start_alu, start_red, start_lsu}); end
    cyc(); #4;
    total++; if ({cfg_we, idle} !== 2'b01) begin
      bad++; $display("FAIL cfg_back_run: got we=%0b idle=%0b want 0 1", cfg_we, idle); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    drv(1, 0, 0, 1, 0, 0, 0, 0, 0, 5'd7, 0, 0);
    cyc();
    drv_idle();
    #4;
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL mid_busy: got idle=%0b want 0", idle); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #4;
    total++; if ({idle, start_mul} !== 2'b10) begin
      bad++; $display("FAIL mid_after_rst: got idle=%0b start=%0b want 1 0", idle, start_mul); end
    cyc();
    done_mul = 1'b1;
    cyc();
    done_mul = 1'b0;
    drv(1, 0, 0, 1, 0, 0, 0, 0, 0, 5'd7, 0, 0);
    #4;
    total++; if ({idle, instr_ready} !== 2'b11) begin
      bad++; $display("FAIL mid_done_ignored: got idle=%0b ready=%0b want 1 1", idle, instr_ready); end
    drv_idle();
  endtask

  task automatic test_saturation();
    do_reset();
    drv(1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 5'd1, 0, 0);
    cyc();
    drv(1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 5'd2, 0, 0);
    for (int i = 0; i < 10; i++) cyc();
    #4;
    total++; if (stall_cnt !== 8'd10) begin bad++; $display("FAIL sat_cnt10: got %0d want 10", stall_cnt); end
    for (int i = 10; i < (1 << SW) + 3; i++) cyc();
    #4;
    total++; if (stall_cnt !== 8'hFF) begin bad++; $display("FAIL sat_hold: got %0d want 255", stall_cnt); end
    drv_idle();
  endtask

  initial begin
    rst = 1'b1;
    drv_idle();
    {done_alu, done_mul, done_red, done_sldu, done_lsu} = '0;
    test_reset();
    test_back_to_back();
    test_priority();
    test_raw();
    test_struct();
    test_vconfig_drain();
    test_reset_midop();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
